// File: rtl/nested_struct_pkg.sv
// Shared types for the nested-struct link: one OuterStruct carries three
// InnerStructs (x, y, z) of three bytes each (a, b, c).
package nested_struct_pkg;
  localparam int FIELD_COUNT = 9;
  localparam int BEAT_W      = 4;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } InnerStruct;

  typedef struct packed {
    InnerStruct x;
    InnerStruct y;
    InnerStruct z;
  } OuterStruct;

  // Field number 0..8 -> {inner struct (x=0,y=1,z=2), byte within it (a=0,b=1,c=2)}
  function automatic logic [3:0] field_sel(input logic [BEAT_W-1:0] field);
    case (field)
      4'd0:    field_sel = {2'd0, 2'd0};
      4'd1:    field_sel = {2'd0, 2'd1};
      4'd2:    field_sel = {2'd0, 2'd2};
      4'd3:    field_sel = {2'd1, 2'd0};
      4'd4:    field_sel = {2'd1, 2'd1};
      4'd5:    field_sel = {2'd1, 2'd2};
      4'd6:    field_sel = {2'd2, 2'd0};
      4'd7:    field_sel = {2'd2, 2'd1};
      default: field_sel = {2'd2, 2'd2};
    endcase
  endfunction
endpackage

// File: rtl/nested_struct_serializer_if.sv
// Capture handshake plus byte-stream output of the struct serializer.
interface nested_struct_serializer_if;
  import nested_struct_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  OuterStruct            in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            out_byte;
  logic [BEAT_W-1:0]     out_index;
  logic                  out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_byte, out_index, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_byte, out_index, out_last
  );
endinterface

// File: rtl/inner_struct_byte_sel.sv
// Picks byte a, b or c out of one InnerStruct.
module inner_struct_byte_sel
  import nested_struct_pkg::*;
(
  input  InnerStruct s,
  input  logic [1:0] sel,
  output logic [7:0] sel_byte
);
  always_comb begin
    case (sel)
      2'd0:    sel_byte = s.a;
      2'd1:    sel_byte = s.b;
      default: sel_byte = s.c;
    endcase
  end
endmodule

// File: rtl/nested_struct_serializer.sv
// Captures one OuterStruct and streams it out one field byte per beat,
// optionally followed by an XOR checksum beat.
module nested_struct_serializer
  import nested_struct_pkg::*;
#(
  parameter bit REVERSE       = 1'b0,
  parameter bit EMIT_CHECKSUM = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  nested_struct_serializer_if.slave  bus
);
  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [BEAT_W-1:0] LAST_IDX  = EMIT_CHECKSUM ? BEAT_W'(FIELD_COUNT) : BEAT_W'(FIELD_COUNT - 1);
  localparam logic [BEAT_W-1:0] CKSUM_IDX = BEAT_W'(FIELD_COUNT);

  state_t            state;
  OuterStruct        hold_reg;
  logic [BEAT_W-1:0] idx;
  logic [BEAT_W-1:0] field;
  logic [7:0]        acc;
  logic [3:0]        sel;
  logic [7:0]        field_byte;
  logic              is_cksum;
  InnerStruct [2:0]  grp;
  logic [2:0][7:0]   grp_byte;

  assign field    = REVERSE ? BEAT_W'(FIELD_COUNT - 1) - idx : idx;
  assign sel      = field_sel(field);
  assign is_cksum = EMIT_CHECKSUM && (idx == CKSUM_IDX);

  // grp[0] = x, grp[1] = y, grp[2] = z
  assign grp = {hold_reg.z, hold_reg.y, hold_reg.x};

  for (genvar g = 0; g < 3; g++) begin : g_sel
    inner_struct_byte_sel u_sel (
      .s        (grp[g]),
      .sel      (sel[1:0]),
      .sel_byte (grp_byte[g])
    );
  end

  always_comb begin
    case (sel[3:2])
      2'd0:    field_byte = grp_byte[0];
      2'd1:    field_byte = grp_byte[1];
      default: field_byte = grp_byte[2];
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == SEND);
  assign bus.out_byte  = is_cksum ? acc : field_byte;
  assign bus.out_index = idx;
  assign bus.out_last  = (state == SEND) && (idx == LAST_IDX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      acc      <= '0;
      hold_reg <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          hold_reg <= bus.in_data;
          idx      <= '0;
          acc      <= '0;
          state    <= SEND;
        end
        SEND: if (bus.out_ready) begin
          if (!is_cksum) acc <= acc ^ field_byte;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) assert (idx <= LAST_IDX);
  end
endmodule

// File: tb/tb_nested_struct_serializer.sv
// Drives identical stimulus into a forward/no-checksum and a reverse/checksum
// serializer and scores every cycle against a frame-queue model.
module tb_nested_struct_serializer;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [71:0] in_data;
  logic        out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    nested_struct_serializer_if bus ();

    nested_struct_serializer #(
      .REVERSE       (g == 1),
      .EMIT_CHECKSUM (g == 1)
    ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
    );

    assign bus.in_valid  = in_valid;
    assign bus.in_data   = in_data;
    assign bus.out_ready = out_ready;

    logic [7:0] exp_b [0:10];
    int len   = 0;
    int pos   = 0;
    bit busy  = 1'b0;
    bit armed = 1'b0;

    // Inputs change just after posedge; here we see what the next edge samples.
    always @(negedge clock) begin
      if (armed) begin
        chk($sformatf("d%0d.in_ready", g), 32'(bus.in_ready), 32'(!busy));
        chk($sformatf("d%0d.out_valid", g), 32'(bus.out_valid), 32'(busy));
        if (busy) begin
          chk($sformatf("d%0d.byte[%0d]", g, pos), 32'(bus.out_byte), 32'(exp_b[pos]));
          chk($sformatf("d%0d.index", g), 32'(bus.out_index), 32'(pos));
          chk($sformatf("d%0d.last[%0d]", g, pos), 32'(bus.out_last), 32'(pos == len - 1));
        end
      end
      if (reset) begin
        busy  = 1'b0;
        armed = 1'b1;
      end else if (!busy && in_valid) begin
        logic [7:0] f [0:8];
        logic [7:0] xs;
        xs = 8'h00;
        for (int i = 0; i < 9; i++) f[i] = in_data[71 - 8*i -: 8];
        for (int k = 0; k < 9; k++) begin
          exp_b[k] = (g == 1) ? f[8 - k] : f[k];
          xs ^= f[k];
        end
        exp_b[9] = xs;
        len  = (g == 1) ? 10 : 9;
        pos  = 0;
        busy = 1'b1;
      end else if (busy && out_ready) begin
        pos++;
        if (pos == len) busy = 1'b0;
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [71:0] d);
    in_data  = d;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(2);

    // basic frame, one beat per cycle
    send(72'h01_02_03_04_05_06_07_08_09);
    cyc(12);

    // backpressure at index 4
    send(72'h01_02_03_04_05_06_07_08_09);
    cyc(4);
    out_ready = 1'b0;
    cyc(3);
    out_ready = 1'b1;
    cyc(12);

    // new struct offered mid-frame must be ignored
    send(72'h11_22_33_44_55_66_77_88_99);
    cyc(3);
    in_data  = 72'hDE_AD_BE_EF_CA_FE_F0_0D_55;
    in_valid = 1'b1;
    cyc(2);
    in_valid = 1'b0;
    cyc(12);

    // reset mid-frame, then clean frame
    send(72'h01_02_03_04_05_06_07_08_09);
    cyc(5);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    send({9{8'hAA}});
    cyc(12);

    // reset wins over capture
    in_data  = 72'h5A_5A_5A_5A_5A_5A_5A_5A_5A;
    in_valid = 1'b1;
    reset    = 1'b1;
    cyc();
    reset    = 1'b0;
    in_valid = 1'b0;
    cyc(2);

    // random traffic with backpressure and occasional reset
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 3) == 0;
      in_data   = {8'($urandom), $urandom, $urandom};
      out_ready = ($urandom % 4) != 0;
      reset     = ($urandom % 200) == 0;
      cyc();
    end
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc(15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
